// File: rtl/piece_mover.sv
// Falling-piece mover: builds spawn/move/rotate candidates,
// bounds-checks them and commits or rejects on the checker verdict.
module piece_mover #(
    parameter int CHECK_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spawn,
    input  logic [15:0] spawn_float,
    input  logic [3:0]  spawn_x,
    input  logic [4:0]  spawn_y,
    input  logic        move_left,
    input  logic        move_right,
    input  logic        move_down,
    input  logic        rotate,
    output logic [3:0]  cand_x,
    output logic [4:0]  cand_y,
    output logic [15:0] cand_float,
    input  logic        valid,
    output logic [3:0]  cur_x,
    output logic [4:0]  cur_y,
    output logic [15:0] cur_float,
    output logic        active,
    output logic        ready,
    output logic        ack,
    output logic        ok,
    output logic        lock,
    output logic        game_over
);

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_DECIDE} state_t;
    typedef enum logic [2:0] {
        OP_SPAWN, OP_ROT, OP_LEFT, OP_RIGHT, OP_DOWN
    } op_t;

    state_t      state_q, state_d;
    op_t         op_q, op_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  cand_x_q, cand_x_d, cur_x_q, cur_x_d;
    logic [4:0]  cand_y_q, cand_y_d, cur_y_q, cur_y_d;
    logic [15:0] cand_f_q, cand_f_d, cur_f_q, cur_f_d;
    logic        active_q, active_d, ready_q, ready_d;
    logic        ack_q, ack_d, ok_q, ok_d;
    logic        lock_q, lock_d, go_q, go_d;

    logic [15:0] rot_float;
    logic        inb;
    logic        accept;
    logic signed [5:0] x_s, y_s, col_s, row_s;

    // clockwise rotation of the committed pattern
    always_comb begin
        rot_float = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                rot_float[4*r+c] = cur_f_q[4*c+3-r];
            end
        end
    end

    // every set cell of the candidate must land on the 10x20 board;
    // y = 31 stands for one row below the floor
    always_comb begin
        inb   = 1'b1;
        x_s   = {2'b00, cand_x_q};
        y_s   = (cand_y_q == 5'h1f) ? 6'h3f : {1'b0, cand_y_q};
        col_s = '0;
        row_s = '0;
        for (int i = 0; i < 16; i++) begin
            col_s = x_s - 6'sd3 + $signed(6'(i % 4));
            row_s = y_s - 6'sd3 + $signed(6'(i / 4));
            if (cand_f_q[i] &&
                (col_s < 6'sd0 || col_s > 6'sd9 ||
                 row_s < 6'sd0 || row_s > 6'sd19)) begin
                inb = 1'b0;
            end
        end
    end

    assign accept = valid & inb;

    // request capture, check countdown and commit/reject decision
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        cand_x_d = cand_x_q;
        cand_y_d = cand_y_q;
        cand_f_d = cand_f_q;
        cur_x_d  = cur_x_q;
        cur_y_d  = cur_y_q;
        cur_f_d  = cur_f_q;
        active_d = active_q;
        ready_d  = ready_q;
        ack_d    = 1'b0;
        ok_d     = 1'b0;
        lock_d   = 1'b0;
        go_d     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cand_x_d = cur_x_q;
                cand_y_d = cur_y_q;
                cand_f_d = cur_f_q;
                if (spawn) begin
                    op_d     = OP_SPAWN;
                    cand_x_d = spawn_x;
                    cand_y_d = spawn_y;
                    cand_f_d = spawn_float;
                end else if (rotate) begin
                    op_d     = OP_ROT;
                    cand_f_d = rot_float;
                end else if (move_left) begin
                    op_d     = OP_LEFT;
                    cand_x_d = cur_x_q - 4'd1;
                end else if (move_right) begin
                    op_d     = OP_RIGHT;
                    cand_x_d = cur_x_q + 4'd1;
                end else begin
                    op_d     = OP_DOWN;
                    cand_y_d = cur_y_q - 5'd1;
                end
                if (spawn || (active_q && (rotate || move_left ||
                              move_right || move_down))) begin
                    state_d = S_CHECK;
                    cnt_d   = '0;
                    ready_d = 1'b0;
                end else begin
                    op_d     = op_q;
                    cand_x_d = cand_x_q;
                    cand_y_d = cand_y_q;
                    cand_f_d = cand_f_q;
                end
            end
            S_CHECK: begin
                if (cnt_q == 8'(CHECK_LAT - 1)) begin
                    state_d = S_DECIDE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DECIDE: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
                ack_d   = 1'b1;
                ok_d    = accept;
                if (accept) begin
                    cur_x_d = cand_x_q;
                    cur_y_d = cand_y_q;
                    cur_f_d = cand_f_q;
                end
                if (op_q == OP_SPAWN) begin
                    active_d = accept;
                    go_d     = ~accept;
                end else if (op_q == OP_DOWN && !accept) begin
                    active_d = 1'b0;
                    lock_d   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_SPAWN;
            cnt_q    <= '0;
            cand_x_q <= '0;
            cand_y_q <= '0;
            cand_f_q <= '0;
            cur_x_q  <= '0;
            cur_y_q  <= '0;
            cur_f_q  <= '0;
            active_q <= 1'b0;
            ready_q  <= 1'b1;
            ack_q    <= 1'b0;
            ok_q     <= 1'b0;
            lock_q   <= 1'b0;
            go_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            cand_x_q <= cand_x_d;
            cand_y_q <= cand_y_d;
            cand_f_q <= cand_f_d;
            cur_x_q  <= cur_x_d;
            cur_y_q  <= cur_y_d;
            cur_f_q  <= cur_f_d;
            active_q <= active_d;
            ready_q  <= ready_d;
            ack_q    <= ack_d;
            ok_q     <= ok_d;
            lock_q   <= lock_d;
            go_q     <= go_d;
        end
    end

    assign cand_x     = cand_x_q;
    assign cand_y     = cand_y_q;
    assign cand_float = cand_f_q;
    assign cur_x      = cur_x_q;
    assign cur_y      = cur_y_q;
    assign cur_float  = cur_f_q;
    assign active     = active_q;
    assign ready      = ready_q;
    assign ack        = ack_q;
    assign ok         = ok_q;
    assign lock       = lock_q;
    assign game_over  = go_q;

endmodule
